// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states,
// instruction classes, opcode/funct values and datapath mux selects.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_SHIFT,
    C_IARITH,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_JAL,
    C_JR,
    C_JALR,
    C_ILLEGAL
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_A      = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_MDR    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Maps the IR opcode/funct fields to the instruction class that steers
// the sequencer; anything not recognised is reported as C_ILLEGAL.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output iclass_e    iclass
);

  always_comb begin
    iclass = C_ILLEGAL;
    case (OpCode)
      OP_RTYPE: begin
        case (Funct)
          FN_SLL, FN_SRL, FN_SRA: iclass = C_SHIFT;
          FN_JR:                  iclass = C_JR;
          FN_JALR:                iclass = C_JALR;
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU:        iclass = C_RTYPE;
          default:                iclass = C_ILLEGAL;
        endcase
      end
      OP_J:    iclass = C_JUMP;
      OP_JAL:  iclass = C_JAL;
      OP_BEQ:  iclass = C_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
               iclass = C_IARITH;
      OP_LW:   iclass = C_LOAD;
      OP_SW:   iclass = C_STORE;
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: steps the shared datapath through
// IF/ID/EX/MEM/WB and stalls IF and MEM on the memory ready handshake.
//
// state | meaning
// S_IF  | fetch at PC, load IR and PC+4 once memory is ready
// S_ID  | register read, branch target into ALUOut, j/jr resolve here
// S_EX  | ALU operation, address calc, or beq compare
// S_MEM | data memory access for lw/sw, held until memory is ready
// S_WB  | register file write (ALU result, load data, or link PC)
module mc_sequencer
  import mc_pkg::*;
#(
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ExtOp,
  output logic       LuOp,
  output logic       instr_done,
  output logic       illegal_op
);

  state_e  state, state_nxt;
  iclass_e iclass;
  logic    mem_ok;

  assign mem_ok = mem_ready | ~WAIT_EN;

  mc_decode u_decode (
    .OpCode (OpCode),
    .Funct  (Funct),
    .iclass (iclass)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = S_IF;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = DST_RT;
    MemtoReg    = WD_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCS_ALU;
    ExtOp       = 1'b0;
    LuOp        = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    // Reset forces every output to zero so no write can slip out mid-abort.
    if (!reset) begin
      case (state)
        S_IF: begin
          MemRead   = 1'b1;
          ALUSrcB   = SRCB_4;
          IRWrite   = mem_ok;
          PCWrite   = mem_ok;
          state_nxt = mem_ok ? S_ID : S_IF;
        end
        S_ID: begin
          ALUSrcB   = SRCB_IMM_SH;
          state_nxt = S_EX;
          case (iclass)
            C_JUMP: begin
              PCWrite    = 1'b1;
              PCSource   = PCS_JUMP;
              instr_done = 1'b1;
              state_nxt  = S_IF;
            end
            C_JR: begin
              PCWrite    = 1'b1;
              PCSource   = PCS_A;
              instr_done = 1'b1;
              state_nxt  = S_IF;
            end
            C_JAL, C_JALR: state_nxt = S_WB;
            C_ILLEGAL: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
              state_nxt  = S_IF;
            end
            default: state_nxt = S_EX;
          endcase
        end
        S_EX: begin
          case (iclass)
            C_RTYPE, C_SHIFT: begin
              ALUSrcA   = (iclass == C_SHIFT) ? SRCA_SHAMT : SRCA_A;
              ALUSrcB   = SRCB_B;
              ALUOp     = ALUOP_FUNCT;
              state_nxt = S_WB;
            end
            C_IARITH: begin
              ALUSrcA   = SRCA_A;
              ALUSrcB   = SRCB_IMM;
              ALUOp     = ALUOP_FUNCT;
              ExtOp     = (OpCode != OP_ANDI);
              LuOp      = (OpCode == OP_LUI);
              state_nxt = S_WB;
            end
            C_LOAD, C_STORE: begin
              ALUSrcA   = SRCA_A;
              ALUSrcB   = SRCB_IMM;
              ExtOp     = 1'b1;
              state_nxt = S_MEM;
            end
            C_BRANCH: begin
              ALUSrcA     = SRCA_A;
              ALUSrcB     = SRCB_B;
              ALUOp       = ALUOP_SUB;
              PCWriteCond = 1'b1;
              PCSource    = PCS_ALUOUT;
              instr_done  = 1'b1;
              state_nxt   = S_IF;
            end
            default: state_nxt = S_IF;
          endcase
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = (iclass == C_LOAD);
          MemWrite = (iclass == C_STORE);
          if (iclass == C_LOAD) begin
            state_nxt = mem_ok ? S_WB : S_MEM;
          end else if (iclass == C_STORE) begin
            instr_done = mem_ok;
            state_nxt  = mem_ok ? S_IF : S_MEM;
          end else begin
            state_nxt = S_IF;
          end
        end
        S_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          case (iclass)
            C_RTYPE, C_SHIFT: begin
              RegDst   = DST_RD;
              MemtoReg = WD_ALUOUT;
            end
            C_LOAD: MemtoReg = WD_MDR;
            C_JAL: begin
              RegDst   = DST_R31;
              MemtoReg = WD_PC;
              PCWrite  = 1'b1;
              PCSource = PCS_JUMP;
            end
            C_JALR: begin
              RegDst   = DST_RD;
              MemtoReg = WD_PC;
              PCWrite  = 1'b1;
              PCSource = PCS_A;
            end
            default: RegDst = DST_RT;
          endcase
        end
        default: state_nxt = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer against a per-instruction
// path model built from the instruction class and memory stall counts.
module tb_mc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] OpCode = 6'h00;
  logic [5:0] Funct = 6'h00;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource;
  logic       ExtOp, LuOp, instr_done, illegal_op;

  mc_sequencer #(.WAIT_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .ExtOp       (ExtOp),
    .LuOp        (LuOp),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_op;
    logic       lu_op;
    logic       done;
    logic       illegal;
  } ovec_t;

  localparam int K_IF = 0, K_ID = 1, K_EX = 2, K_MEM = 3, K_WB = 4;
  localparam int CR = 0, CSH = 1, CIA = 2, CLW = 3, CSW = 4, CBQ = 5;
  localparam int CJ = 6, CJAL = 7, CJR = 8, CJALR = 9, CILL = 10;

  logic [5:0] legal_ops [12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09,
                                 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b};
  logic [5:0] legal_fns [15] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21,
                                 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

  int errors = 0;
  int checks = 0;

  function automatic int cls_of(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03}) return CSH;
      if (fn == 6'h08) return CJR;
      if (fn == 6'h09) return CJALR;
      if (fn inside {[6'h20:6'h27], 6'h2a, 6'h2b}) return CR;
      return CILL;
    end
    case (op)
      6'h02: return CJ;
      6'h03: return CJAL;
      6'h04: return CBQ;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: return CIA;
      6'h23: return CLW;
      6'h2b: return CSW;
      default: return CILL;
    endcase
  endfunction

  // Expected control word for one cycle of a given phase of an instruction.
  function automatic ovec_t model(int k, logic [5:0] op, logic [5:0] fn, logic rdy);
    ovec_t o;
    int c;
    o = '0;
    c = cls_of(op, fn);
    if (k == K_IF) begin
      o.mem_read = 1'b1;
      o.src_b    = 2'd1;
      o.ir_write = rdy;
      o.pc_write = rdy;
    end else if (k == K_ID) begin
      o.src_b = 2'd3;
      if (c == CJ || c == CJR) begin
        o.pc_write = 1'b1;
        o.pc_src   = (c == CJ) ? 2'd2 : 2'd3;
        o.done     = 1'b1;
      end
      if (c == CILL) begin
        o.illegal = 1'b1;
        o.done    = 1'b1;
      end
    end else if (k == K_EX) begin
      if (c == CR || c == CSH) begin
        o.src_a  = (c == CSH) ? 2'd2 : 2'd1;
        o.alu_op = 2'd2;
      end else if (c == CIA) begin
        o.src_a  = 2'd1;
        o.src_b  = 2'd2;
        o.alu_op = 2'd2;
        o.ext_op = (op != 6'h0c);
        o.lu_op  = (op == 6'h0f);
      end else if (c == CLW || c == CSW) begin
        o.src_a  = 2'd1;
        o.src_b  = 2'd2;
        o.ext_op = 1'b1;
      end else if (c == CBQ) begin
        o.src_a         = 2'd1;
        o.alu_op        = 2'd1;
        o.pc_write_cond = 1'b1;
        o.pc_src        = 2'd1;
        o.done          = 1'b1;
      end
    end else if (k == K_MEM) begin
      o.iord      = 1'b1;
      o.mem_read  = (c == CLW);
      o.mem_write = (c == CSW);
      o.done      = (c == CSW) && rdy;
    end else begin
      o.reg_write = 1'b1;
      o.done      = 1'b1;
      if (c == CR || c == CSH) o.reg_dst = 2'd1;
      if (c == CLW) o.mem_to_reg = 2'd1;
      if (c == CJAL) begin
        o.reg_dst = 2'd2; o.mem_to_reg = 2'd2; o.pc_write = 1'b1; o.pc_src = 2'd2;
      end
      if (c == CJALR) begin
        o.reg_dst = 2'd1; o.mem_to_reg = 2'd2; o.pc_write = 1'b1; o.pc_src = 2'd3;
      end
    end
    return o;
  endfunction

  function automatic ovec_t sample();
    ovec_t o;
    o = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
          RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
          ExtOp, LuOp, instr_done, illegal_op};
    return o;
  endfunction

  // One clock cycle: drive just after the rising edge, sample at the falling edge.
  task automatic step(input logic rst, input logic rdy, input logic [5:0] op,
                      input logic [5:0] fn, output ovec_t got);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    OpCode    = op;
    Funct     = fn;
    @(negedge clk);
    got = sample();
  endtask

  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int if_st, input int mem_st, input string tag);
    int    path[$];
    int    c, n;
    logic  rdy;
    ovec_t got, exp;
    c = cls_of(op, fn);
    path.push_back(K_IF);
    path.push_back(K_ID);
    if (c inside {CR, CSH, CIA, CLW, CSW, CBQ}) path.push_back(K_EX);
    if (c inside {CLW, CSW}) path.push_back(K_MEM);
    if (c inside {CR, CSH, CIA, CLW, CJAL, CJALR}) path.push_back(K_WB);
    foreach (path[i]) begin
      n = (path[i] == K_IF) ? if_st : (path[i] == K_MEM) ? mem_st : 0;
      for (int s = 0; s <= n; s++) begin
        if (path[i] == K_IF || path[i] == K_MEM) rdy = (s == n);
        else rdy = 1'($urandom_range(0, 1));
        if (path[i] == K_IF) step(1'b0, rdy, 6'($urandom), 6'($urandom), got);
        else step(1'b0, rdy, op, fn, got);
        exp = model(path[i], op, fn, rdy);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s op=%h fn=%h phase%0d stall%0d: got=%h expected=%h",
                   tag, op, fn, path[i], s, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    ovec_t got;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom), got);
      checks++;
      if (got !== ovec_t'('0)) begin
        errors++;
        $display("FAIL reset_hold cycle%0d: got=%h expected=0", i, got);
      end
    end
    step(1'b0, 1'b1, 6'($urandom), 6'($urandom), got);
    checks++;
    if (got !== model(K_IF, 6'h00, 6'h00, 1'b1)) begin
      errors++;
      $display("FAIL first_fetch: got=%h expected=%h", got, model(K_IF, 6'h00, 6'h00, 1'b1));
    end
    step(1'b0, 1'b1, 6'h02, 6'h00, got);
    checks++;
    if (got !== model(K_ID, 6'h02, 6'h00, 1'b1)) begin
      errors++;
      $display("FAIL first_decode: got=%h expected=%h", got, model(K_ID, 6'h02, 6'h00, 1'b1));
    end
  endtask

  task automatic test_basic();
    exec_instr(6'h00, 6'h20, 0, 0, "add");
    exec_instr(6'h04, 6'h11, 0, 0, "beq");
    exec_instr(6'h00, 6'h02, 0, 0, "srl");
    exec_instr(6'h0c, 6'h3f, 0, 0, "andi");
    exec_instr(6'h0f, 6'h00, 0, 0, "lui");
    exec_instr(6'h2b, 6'h05, 0, 0, "sw");
    exec_instr(6'h23, 6'h05, 0, 0, "lw");
  endtask

  task automatic test_lw_stalls();
    exec_instr(6'h23, 6'h00, 2, 3, "lw_stall");
    exec_instr(6'h2b, 6'h00, 1, 2, "sw_stall");
  endtask

  task automatic test_jumps();
    exec_instr(6'h03, 6'h00, 0, 0, "jal");
    exec_instr(6'h00, 6'h08, 0, 0, "jr");
    exec_instr(6'h02, 6'h00, 1, 0, "j");
    exec_instr(6'h00, 6'h09, 0, 0, "jalr");
  endtask

  task automatic test_illegal();
    exec_instr(6'h3f, 6'h00, 0, 0, "illegal_op");
    exec_instr(6'h00, 6'h3f, 0, 0, "illegal_fn");
    exec_instr(6'h05, 6'h00, 1, 0, "bne_unsupported");
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 11)];
      else op = 6'($urandom);
      if ($urandom_range(0, 3) != 0) fn = legal_fns[$urandom_range(0, 14)];
      else fn = 6'($urandom);
      exec_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_reset_mid();
    ovec_t got;
    step(1'b0, 1'b1, 6'($urandom), 6'($urandom), got);
    checks++;
    if (got !== model(K_IF, 6'h2b, 6'h00, 1'b1)) begin
      errors++;
      $display("FAIL rmid_if: got=%h expected=%h", got, model(K_IF, 6'h2b, 6'h00, 1'b1));
    end
    step(1'b0, 1'b1, 6'h2b, 6'h00, got);
    step(1'b0, 1'b1, 6'h2b, 6'h00, got);
    checks++;
    if (got !== model(K_EX, 6'h2b, 6'h00, 1'b1)) begin
      errors++;
      $display("FAIL rmid_ex: got=%h expected=%h", got, model(K_EX, 6'h2b, 6'h00, 1'b1));
    end
    step(1'b0, 1'b0, 6'h2b, 6'h00, got);
    checks++;
    if (got !== model(K_MEM, 6'h2b, 6'h00, 1'b0)) begin
      errors++;
      $display("FAIL rmid_mem_stall: got=%h expected=%h", got, model(K_MEM, 6'h2b, 6'h00, 1'b0));
    end
    step(1'b1, 1'b0, 6'h2b, 6'h00, got);
    checks++;
    if (got !== ovec_t'('0)) begin
      errors++;
      $display("FAIL rmid_reset_cycle: got=%h expected=0 (MemWrite=%b)", got, got.mem_write);
    end
    step(1'b1, 1'b1, 6'h2b, 6'h00, got);
    checks++;
    if (got !== ovec_t'('0)) begin
      errors++;
      $display("FAIL rmid_reset_hold: got=%h expected=0", got);
    end
    step(1'b0, 1'b1, 6'($urandom), 6'($urandom), got);
    checks++;
    if (got !== model(K_IF, 6'h00, 6'h00, 1'b1)) begin
      errors++;
      $display("FAIL rmid_refetch: got=%h expected=%h", got, model(K_IF, 6'h00, 6'h00, 1'b1));
    end
  endtask

  initial begin
    test_reset();
    exec_instr(6'h02, 6'h00, 0, 0, "warmup_j_tail");
    test_basic();
    test_lw_stalls();
    test_jumps();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the MIPS processor core. It replaces the single-cycle combinational controller with a state machine that steps the shared datapath (one ALU, one unified memory port, IR/A/B/ALUOut/MDR holding registers) through IF, ID, EX, MEM and WB. It drives every datapath enable and mux select, and it stalls on a memory ready handshake.

## Interface
- `WAIT_EN`, default 1: 1 = honour `mem_ready`; 0 = treat `mem_ready` as constant 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `OpCode` in 6: IR[31:26]; valid from the cycle after IF completes.
- `Funct` in 6: IR[5:0].
- `mem_ready` in 1: the memory has completed the current read/write this cycle.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load if ALU `zero`.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite` out 1: memory strobes.
- `IRWrite` out 1: IR load.
- `RegWrite` out 1: register file write.
- `RegDst` out 2: write register select; 0 = Rt, 1 = Rd, 2 = $31.
- `MemtoReg` out 2: write data select; 0 = ALUOut, 1 = MDR, 2 = PC.
- `ALUSrcA` out 2: 0 = PC, 1 = A, 2 = shamt.
- `ALUSrcB` out 2: 0 = B, 1 = const 4, 2 = imm ext, 3 = imm ext << 2.
- `ALUOp` out 2: 0 = add, 1 = sub, 2 = decode from OpCode/Funct.
- `PCSource` out 2: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A.
- `ExtOp`, `LuOp` out 1: immediate sign-extend / lui select.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal_op` out 1: one-cycle pulse in ID for an unsupported opcode or funct.

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. Any other encoding → IF next cycle.
- Outputs are a combinational decode of the state and OpCode/Funct.
- Outputs not listed for a state are 0.
- **IF**
  - Strobes: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=1, `ALUOp`=0, `PCSource`=0.
  - `IRWrite` and `PCWrite` = `mem_ready`.
  - Advance to ID only when `mem_ready`=1.
- **ID**
  - Strobes: `ALUSrcA`=0, `ALUSrcB`=3, `ALUOp`=0 (precompute branch target into ALUOut).
  - j (0x02): `PCWrite`=1, `PCSource`=2, `instr_done` → IF.
  - jr (R, funct 0x08): `PCWrite`=1, `PCSource`=3, `instr_done` → IF.
  - jal (0x03) and jalr (R, funct 0x09) → WB.
  - Unsupported opcode/funct: `illegal_op`=1, `instr_done`=1 → IF.
  - All other instructions → EX.
- **EX**
  - R-type: `ALUSrcA`=1, or 2 for sll/srl/sra (funct 0x00/0x02/0x03). `ALUSrcB`=0, `ALUOp`=2 → WB.
  - I-arith (addi 0x08, addiu 0x09, andi 0x0c, slti 0x0a, sltiu 0x0b, lui 0x0f): `ALUSrcA`=1, `ALUSrcB`=2, `ALUOp`=2 → WB.
    - `ExtOp`=0 for andi; `LuOp`=1 for lui.
  - lw/sw (0x23/0x2b): `ALUSrcA`=1, `ALUSrcB`=2, `ALUOp`=0, `ExtOp`=1 → MEM.
  - beq (0x04): `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=1, `PCWriteCond`=1, `PCSource`=1, `instr_done` → IF.
- **MEM**
  - Strobes: `IorD`=1; `MemRead` (lw) or `MemWrite` (sw) held until `mem_ready`.
  - On `mem_ready`: lw → WB; sw → `instr_done`, IF.
- **WB**
  - Strobes: `RegWrite`=1, `instr_done`=1 → IF.
  - R-type: `RegDst`=1, `MemtoReg`=0.
  - I-arith: `RegDst`=0, `MemtoReg`=0.
  - lw: `RegDst`=0, `MemtoReg`=1.
  - jal: `RegDst`=2, `MemtoReg`=2, `PCWrite`=1, `PCSource`=2.
  - jalr: `RegDst`=1, `MemtoReg`=2, `PCWrite`=1, `PCSource`=3.
  - For jal/jalr, the PC already holds PC+4; the register write and the PC load occur on the same edge.

## Timing
- While `reset`=1:
  - All outputs are forced to 0; this is the reset value of every output.
  - The state loads IF on the edge.
- First fetch occurs in the cycle after `reset` deasserts.
- Latency with zero wait states:
  - j/jr: 2 cycles.
  - beq/jal/jalr: 3 cycles.
  - R-type, I-arith, sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle with `mem_ready`=0 in IF or MEM adds one cycle.
  - During a stall the strobes stay stable.
  - No PC, IR or register write occurs during a stall.
- `mem_ready` is ignored outside IF/MEM.
- `reset` mid-instruction (including mid-stall) aborts the instruction.
  - No write strobe is asserted in the reset cycle.
- `instr_done` and `illegal_op` never assert in consecutive cycles.

## Structure
- The shared package `mc_pkg` holds:
  - state encodings;
  - opcode and funct constants;
  - `ALUSrcA`/`ALUSrcB`/`PCSource`/`RegDst`/`MemtoReg`/`ALUOp` encodings.
- The sub-module `mc_decode` maps OpCode/Funct to an instruction class: RTYPE, SHIFT, IARITH, LOAD, STORE, BRANCH, JUMP, JAL, JR, JALR, ILLEGAL.
- `mc_sequencer` holds the state register and the per-state output decode.

## Test plan
- **Reset:** hold `reset` 3 cycles → all outputs 0 throughout; the first post-reset cycle shows `MemRead`=1, `IorD`=0, `IRWrite`=1.
- **Basic classes, `mem_ready` tied 1:**
  - add → states IF, ID, EX, WB; `RegDst`=1, `RegWrite`=1 in cycle 4; `instr_done` in cycle 4.
  - beq → done in 3 cycles with `PCWriteCond`=1, `PCSource`=1 in EX.
- **lw with stalls:** lw with `mem_ready` low for 2 cycles in IF and 3 cycles in MEM → 10 cycles total; `IRWrite` asserts only in the IF cycle where `mem_ready`=1; WB has `MemtoReg`=1.
- **Jumps:**
  - jal → WB with `RegDst`=2, `MemtoReg`=2, `PCWrite`=1, `PCSource`=2.
  - jr → `PCSource`=3 in ID; `instr_done` at cycle 2.
- **Illegal opcode:** opcode 0x3f → `illegal_op` and `instr_done` pulse once in ID; no write strobes; next cycle is IF.
- **Reset mid-instruction:** assert `reset` during MEM of sw with `mem_ready`=0 → `MemWrite` drops to 0 in that cycle; IF resumes after deassertion.
